// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issuer: opcodes, FSM encoding, default
// settle time, formatted response record and the opcode-to-selector mapping.
package alu_pkg;

   // Default number of clocks the external ALU is given to settle.
   localparam int unsigned SETTLE_CYCLES_DEF = 4;

   // Width of the settle down-counter.
   localparam int unsigned CNT_W = 8;

   // Request opcodes; the numeric values double as ALU selector codes.
   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_SUB  = 3'd1,
      OP_XOR  = 3'd2,
      OP_SLT  = 3'd3,
      OP_AND  = 3'd4,
      OP_NAND = 3'd5,
      OP_NOR  = 3'd6,
      OP_OR   = 3'd7
   } op_e;

   // Issuer FSM states.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   // Final result and flags as presented on the response channel.
   typedef struct packed {
      logic [31:0] result;
      logic        carry;
      logic        over;
      logic        zero;
   } rsp_t;

   // The ALU has no compare mode: set-less-than is computed from a subtraction.
   function automatic op_e alu_sel_of(input op_e op);
      return (op == OP_SLT) ? OP_SUB : op;
   endfunction

endpackage

// File: rtl/alu_issuer_if.sv
// Bundle of the request, ALU and response channels of the issuer.
// slave: the issuer's view. master: the environment (requester, ALU, consumer).
interface alu_issuer_if;

   // Request channel
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [2:0]  req_op;

   // ALU operand/selector outputs and ALU result inputs
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [2:0]  alu_sel;
   logic [31:0] alu_out;
   logic        alu_carry;
   logic        alu_over;
   logic        alu_zero;

   // Response channel
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic        rsp_carry;
   logic        rsp_over;
   logic        rsp_zero;

   // Status
   logic        busy;

   modport slave (
      input  req_valid, req_a, req_b, req_op,
      input  alu_out, alu_carry, alu_over, alu_zero,
      input  rsp_ready,
      output req_ready,
      output alu_a, alu_b, alu_sel,
      output rsp_valid, rsp_result, rsp_carry, rsp_over, rsp_zero,
      output busy
   );

   modport master (
      output req_valid, req_a, req_b, req_op,
      output alu_out, alu_carry, alu_over, alu_zero,
      output rsp_ready,
      input  req_ready,
      input  alu_a, alu_b, alu_sel,
      input  rsp_valid, rsp_result, rsp_carry, rsp_over, rsp_zero,
      input  busy
   );

endinterface

// File: rtl/alu_result_fmt.sv
// Turns raw ALU outputs into the final response value for the latched opcode:
// arithmetic ops pass flags through, SLT reduces to 0/1, logic ops mask
// carry/overflow whatever the ALU reports.
module alu_result_fmt
   import alu_pkg::*;
(
   input  op_e         op,
   input  logic [31:0] alu_out,
   input  logic        alu_carry,
   input  logic        alu_over,
   input  logic        alu_zero,
   output rsp_t        fmt
);

   logic slt_bit;

   // Signed less-than from the subtraction: sign of the difference corrected by overflow.
   assign slt_bit = alu_out[31] ^ alu_over;

   // Per-opcode selection of result and flags.
   always_comb begin
      fmt.result = alu_out;
      fmt.carry  = 1'b0;
      fmt.over   = 1'b0;
      fmt.zero   = alu_zero;
      unique case (op)
         OP_ADD, OP_SUB: begin
            fmt.carry = alu_carry;
            fmt.over  = alu_over;
         end
         OP_SLT: begin
            fmt.result = {31'd0, slt_bit};
            fmt.zero   = ~slt_bit;
         end
         default: begin
            // Logic ops: result and zero from the ALU, carry/overflow forced low.
            fmt.result = alu_out;
         end
      endcase
   end

endmodule

// File: rtl/alu_issuer.sv
// Single-outstanding ALU issuer: accepts one request, drives registered
// operands to an external combinational ALU, waits SETTLE_CYCLES clocks,
// captures the formatted result and holds it until the consumer takes it.
module alu_issuer
   import alu_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
   input  logic         clk,
   input  logic         reset_n,
   alu_issuer_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   state_e           state_q,   state_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic [31:0]      alu_a_q,   alu_a_d;
   logic [31:0]      alu_b_q,   alu_b_d;
   op_e              alu_sel_q, alu_sel_d;
   op_e              op_q,      op_d;
   logic             rsp_valid_q, rsp_valid_d;
   rsp_t             rsp_q,     rsp_d;

   rsp_t             fmt;
   logic             accept;

   // Formatting of the live ALU outputs under the latched opcode.
   alu_result_fmt u_fmt (
      .op        (op_q),
      .alu_out   (bus.alu_out),
      .alu_carry (bus.alu_carry),
      .alu_over  (bus.alu_over),
      .alu_zero  (bus.alu_zero),
      .fmt       (fmt)
   );

   // Ready only when idle and out of reset; requests outside IDLE are ignored.
   assign bus.req_ready = reset_n && (state_q == ST_IDLE);
   assign accept        = bus.req_valid && (state_q == ST_IDLE);

   // Next-state, counter, operand and response register logic.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_sel_d   = alu_sel_q;
      op_d        = op_q;
      rsp_valid_d = rsp_valid_q;
      rsp_d       = rsp_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               alu_a_d   = bus.req_a;
               alu_b_d   = bus.req_b;
               op_d      = op_e'(bus.req_op);
               alu_sel_d = alu_sel_of(op_e'(bus.req_op));
               cnt_d     = CNT_LOAD;
               state_d   = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == '0) begin
               rsp_d       = fmt;
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RESP: begin
            // Operands stay put here so the ALU outputs remain consistent until the handshake.
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_sel_q   <= OP_ADD;
         op_q        <= OP_ADD;
         rsp_valid_q <= 1'b0;
         rsp_q       <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_sel_q   <= alu_sel_d;
         op_q        <= op_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_q       <= rsp_d;
      end
   end

   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.alu_sel    = alu_sel_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_result = rsp_q.result;
   assign bus.rsp_carry  = rsp_q.carry;
   assign bus.rsp_over   = rsp_q.over;
   assign bus.rsp_zero   = rsp_q.zero;
   assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_issuer.sv
// Bench for alu_issuer: behavioural ALU on the operand bus, a reference model
// of the whole request->response transformation checked every cycle, and
// directed vectors with hand-computed literal expectations.
module tb_alu_issuer;

   localparam int S = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic force_flags = 1'b0;

   int tests = 0;
   int fails = 0;

   alu_issuer_if bus ();

   alu_issuer #(.SETTLE_CYCLES(S)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: combinational, selector 3 deliberately returns junk.
   logic [32:0] alu_sum;
   always_comb begin
      alu_sum       = '0;
      bus.alu_out   = '0;
      bus.alu_carry = force_flags;
      bus.alu_over  = force_flags;
      case (bus.alu_sel)
         3'd0: begin
            alu_sum       = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            bus.alu_out   = alu_sum[31:0];
            bus.alu_carry = alu_sum[32];
            bus.alu_over  = (bus.alu_a[31] == bus.alu_b[31]) && (alu_sum[31] != bus.alu_a[31]);
         end
         3'd1: begin
            alu_sum       = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
            bus.alu_out   = alu_sum[31:0];
            bus.alu_carry = alu_sum[32];
            bus.alu_over  = (bus.alu_a[31] != bus.alu_b[31]) && (alu_sum[31] != bus.alu_a[31]);
         end
         3'd2: bus.alu_out = bus.alu_a ^ bus.alu_b;
         3'd3: bus.alu_out = 32'hDEAD_BEEF;
         3'd4: bus.alu_out = bus.alu_a & bus.alu_b;
         3'd5: bus.alu_out = ~(bus.alu_a & bus.alu_b);
         3'd6: bus.alu_out = ~(bus.alu_a | bus.alu_b);
         default: bus.alu_out = bus.alu_a | bus.alu_b;
      endcase
      bus.alu_zero = (bus.alu_out == 32'd0);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference: what the response must be, from plain signed/unsigned arithmetic.
   function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic c, output logic o, output logic z);
      longint sa, sb, sr;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      c  = 1'b0;
      o  = 1'b0;
      case (op)
         3'd0: begin
            r  = a + b;
            sr = sa + sb;
            c  = (longint'(a) + longint'(b)) > 64'sd4294967295;
            o  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
         end
         3'd1: begin
            r  = a - b;
            sr = sa - sb;
            c  = (a >= b);
            o  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
         end
         3'd2: r = a ^ b;
         3'd3: r = (sa < sb) ? 32'd1 : 32'd0;
         3'd4: r = a & b;
         3'd5: r = ~(a & b);
         3'd6: r = ~(a | b);
         default: r = a | b;
      endcase
      z = (r == 32'd0);
   endfunction

   // Per-cycle compare against the reference model.
   int          cyc = 0;
   int          acc_cyc = 0;
   bit          in_flight = 0;
   logic [31:0] m_a, m_b, m_r;
   logic [2:0]  m_sel;
   logic        m_c, m_o, m_z;
   bit          exp_v;

   always @(negedge clk) begin
      cyc++;
      if (!reset_n) begin
         in_flight = 0;
         chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
         chk("rst_busy", 32'(bus.busy), 32'd0);
         chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
         chk("rst_rsp_result", bus.rsp_result, 32'd0);
         chk("rst_rsp_flags", {29'd0, bus.rsp_carry, bus.rsp_over, bus.rsp_zero}, 32'd0);
         chk("rst_alu_a", bus.alu_a, 32'd0);
         chk("rst_alu_b", bus.alu_b, 32'd0);
         chk("rst_alu_sel", 32'(bus.alu_sel), 32'd0);
      end else begin
         chk("req_ready", 32'(bus.req_ready), 32'(!in_flight));
         chk("busy", 32'(bus.busy), 32'(in_flight));
         if (in_flight) begin
            chk("alu_a_stable", bus.alu_a, m_a);
            chk("alu_b_stable", bus.alu_b, m_b);
            chk("alu_sel_stable", 32'(bus.alu_sel), 32'(m_sel));
            exp_v = (cyc - acc_cyc) > S;
            chk("rsp_valid_timing", 32'(bus.rsp_valid), 32'(exp_v));
            if (exp_v) begin
               chk("model_result", bus.rsp_result, m_r);
               chk("model_flags", {29'd0, bus.rsp_carry, bus.rsp_over, bus.rsp_zero},
                   {29'd0, m_c, m_o, m_z});
               if (bus.rsp_ready) in_flight = 0;
            end
         end else begin
            chk("rsp_valid_idle", 32'(bus.rsp_valid), 32'd0);
            if (bus.req_valid) begin
               m_a   = bus.req_a;
               m_b   = bus.req_b;
               m_sel = (bus.req_op == 3'd3) ? 3'd1 : bus.req_op;
               ref_op(bus.req_op, bus.req_a, bus.req_b, m_r, m_c, m_o, m_z);
               in_flight = 1;
               acc_cyc   = cyc;
            end
         end
      end
   end

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      bit          frc;
      logic [31:0] r;
      logic        c;
      logic        o;
      logic        z;
   } vec_t;

   vec_t vecs[12];

   // Issue one request and check the response against literal expectations.
   task automatic run_vec(input vec_t v);
      int n;
      bit got;
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.req_a     = v.a;
      bus.req_b     = v.b;
      bus.req_op    = v.op;
      force_flags   = v.frc;
      got = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.req_ready) begin
            got = 1;
            break;
         end
      end
      if (!got) begin
         tests++; fails++;
         $display("FAIL accept_timeout: req_ready never high, required 1");
      end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.req_a     = $urandom;
      bus.req_b     = $urandom;
      bus.req_op    = 3'($urandom);
      n = 0;
      got = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         n++;
         if (bus.rsp_valid) begin
            got = 1;
            break;
         end
      end
      chk("rsp_seen", 32'(got), 32'd1);
      chk("latency", 32'(n), 32'(S + 1));
      chk("lit_alu_sel", 32'(bus.alu_sel), (v.op == 3'd3) ? 32'd1 : 32'(v.op));
      chk("lit_result", bus.rsp_result, v.r);
      chk("lit_carry", 32'(bus.rsp_carry), 32'(v.c));
      chk("lit_over", 32'(bus.rsp_over), 32'(v.o));
      chk("lit_zero", 32'(bus.rsp_zero), 32'(v.z));
      $display("[TB] op=%0d a=%08h b=%08h -> result=%08h c=%0b o=%0b z=%0b lat=%0d",
               v.op, v.a, v.b, bus.rsp_result, bus.rsp_carry, bus.rsp_over, bus.rsp_zero, n);
      if (bus.rsp_ready) begin
         @(posedge clk); #1;
         force_flags = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t bp;
      vec_t ad;
      vecs = '{
         '{3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1},
         '{3'd1, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0},
         '{3'd3, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0},
         '{3'd3, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1},
         '{3'd2, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1},
         '{3'd4, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1, 32'h0F00_0F00, 1'b0, 1'b0, 1'b0},
         '{3'd5, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 32'hF0FF_F0FF, 1'b0, 1'b0, 1'b0},
         '{3'd6, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1, 32'h000F_000F, 1'b0, 1'b0, 1'b0},
         '{3'd7, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0},
         '{3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0},
         '{3'd1, 32'h0000_0003, 32'h0000_0005, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0},
         '{3'd3, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0}
      };
      bus.req_valid = 1'b0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_op    = '0;
      bus.rsp_ready = 1'b1;

      // Reset, checked by the compare process on each low negedge.
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Back-pressure: response held 10 clocks while request inputs toggle.
      bus.rsp_ready = 1'b0;
      bp = '{3'd1, 32'd10, 32'd4, 1'b0, 32'd6, 1'b1, 1'b0, 1'b0};
      run_vec(bp);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         bus.req_valid = ~bus.req_valid;
         bus.req_a     = $urandom;
         bus.req_b     = $urandom;
         bus.req_op    = 3'($urandom);
         @(negedge clk);
         chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
         chk("bp_result", bus.rsp_result, 32'd6);
         chk("bp_alu_a", bus.alu_a, 32'd10);
      end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_valid_before_hs", 32'(bus.rsp_valid), 32'd1);
      @(negedge clk);
      chk("bp_valid_after_hs", 32'(bus.rsp_valid), 32'd0);
      chk("bp_ready_after_hs", 32'(bus.req_ready), 32'd1);

      // Reset two clocks into SETTLE aborts the operation.
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.req_a     = 32'd7;
      bus.req_b     = 32'd8;
      bus.req_op    = 3'd0;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
      repeat (S + 3) begin
         @(negedge clk);
         chk("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
      end
      ad = '{3'd0, 32'd2, 32'd3, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0};
      run_vec(ad);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
